lsu_stage: RTL and testbench

- Load/store unit between the execute stage and the byte-addressed `ram` block.
- Accepts one memory request per handshake and decodes size and signedness.
- Checks alignment and range, drives the RAM's size/sign/data ports for exactly one cycle, then holds the response until the pipeline takes it.
- Keeps RAM write enables at 0 whenever no store is active, so no spurious writes occur.

---
 rtl/lsu_stage_pkg.sv | 67 ++++++
 rtl/lsu_check.sv | 66 ++++++
 rtl/lsu_stage.sv | 205 ++++++++++++++++++++
 tb/tb_lsu_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store unit: op field positions, size and
// exception codes, FSM state encoding, default memory size and a helper that
// extends right-justified load data.
// Optional feature macro: LSU_MMIO_EN (memory-mapped I/O window).
`ifndef MEM_SIZE
`define MEM_SIZE 1024
`endif

package lsu_stage_pkg;

  localparam int unsigned DEF_MEM_SIZE = `MEM_SIZE;
`ifdef LSU_MMIO_EN
  localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF0000;
`endif

  // op field positions
  localparam int OP_STORE_BIT    = 3;
  localparam int OP_UNSIGNED_BIT = 2;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_code_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MISALIGN = 2'd1,
    EXC_BUS      = 2'd2,
    EXC_ILLEGAL  = 2'd3
  } exc_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_RESP      = 2'd2,
    ST_MMIO_WAIT = 2'd3
  } state_e;

  // Number of bytes moved for a size code; 0 for the illegal code.
  function automatic logic [2:0] size_bytes(input logic [1:0] code);
    logic [2:0] n;
    case (code)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Sign- or zero-extend right-justified data of the given size to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  code,
                                              input logic        uns);
    logic [31:0] r;
    case (code)
      SZ_BYTE: r = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
      SZ_HALF: r = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      SZ_WORD: r = raw;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_check.sv
// Combinational request checker: decodes the op, yields the byte count and
// the highest-priority exception (illegal > misaligned > bus error).
// Kept stand-alone so a fetch-side checker can reuse it.
// Optional feature macro: LSU_MMIO_EN (addresses >= MMIO_BASE skip the range check).
module lsu_check
  import lsu_stage_pkg::*;
#(
  parameter int unsigned MEM_SIZE = DEF_MEM_SIZE
`ifdef LSU_MMIO_EN
  , parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE
`endif
) (
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  output logic        is_store,
  output logic        is_unsigned,
  output logic [2:0]  nbytes,
`ifdef LSU_MMIO_EN
  output logic        is_mmio,
`endif
  output logic [1:0]  exc
);

  logic [32:0] end_addr;
  logic        illegal;
  logic        misaligned;
  logic        in_mmio;
  logic        out_of_range;

  // Decode the op and rank the possible faults for this request.
  always_comb begin
    is_store    = op[OP_STORE_BIT];
    is_unsigned = op[OP_UNSIGNED_BIT];
    nbytes      = size_bytes(op[1:0]);
    end_addr    = {1'b0, addr} + {30'd0, nbytes};
    illegal     = (op[1:0] == SZ_ILLEGAL);

    case (op[1:0])
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = |addr[1:0];
      default: misaligned = 1'b0;
    endcase

`ifdef LSU_MMIO_EN
    in_mmio = (addr >= MMIO_BASE);
    is_mmio = in_mmio;
`else
    in_mmio = 1'b0;
`endif

    // 33-bit compare so an access touching the top of the address space
    // cannot wrap back into range.
    out_of_range = !in_mmio && (end_addr > 33'(MEM_SIZE));

    if (illegal) begin
      exc = EXC_ILLEGAL;
    end else if (misaligned) begin
      exc = EXC_MISALIGN;
    end else if (out_of_range) begin
      exc = EXC_BUS;
    end else begin
      exc = EXC_NONE;
    end
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store unit between execute and the byte-addressed big-endian RAM.
// A request is latched in IDLE, checked on the following cycle, then either
// answered with an exception or sent to the RAM for exactly one ACCESS cycle.
// The response is held in RESP until the consumer takes it.
// Optional feature macro: LSU_MMIO_EN (adds an MMIO port and MMIO_WAIT state).
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int unsigned MEM_SIZE = DEF_MEM_SIZE
`ifdef LSU_MMIO_EN
  , parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_exc,
  output logic [31:0] o_badaddr,
  output logic [31:0] o_ram_addr,
  output logic [2:0]  o_ram_rsize,
  output logic        o_ram_rsign,
  output logic [2:0]  o_ram_wsize,
  output logic [31:0] o_ram_wdata,
`ifdef LSU_MMIO_EN
  output logic        o_mmio_req,
  output logic        o_mmio_we,
  output logic [31:0] o_mmio_addr,
  output logic [31:0] o_mmio_wdata,
  output logic [2:0]  o_mmio_size,
  input  logic        i_mmio_ack,
  input  logic [31:0] i_mmio_rdata,
`endif
  input  logic [31:0] i_ram_rdata
);

  state_e      state_r;
  logic        pending_r;   // request latched in IDLE, check runs this cycle
  logic [3:0]  op_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  logic        chk_is_store;
  logic        chk_is_unsigned;
  logic [2:0]  chk_nbytes;
  logic [1:0]  chk_exc;
`ifdef LSU_MMIO_EN
  logic        chk_is_mmio;
`endif

  lsu_check #(
    .MEM_SIZE    (MEM_SIZE)
`ifdef LSU_MMIO_EN
    , .MMIO_BASE (MMIO_BASE)
`endif
  ) u_check (
    .op          (op_r),
    .addr        (addr_r),
    .is_store    (chk_is_store),
    .is_unsigned (chk_is_unsigned),
    .nbytes      (chk_nbytes),
`ifdef LSU_MMIO_EN
    .is_mmio     (chk_is_mmio),
`endif
    .exc         (chk_exc)
  );

  // Request/response FSM with all outputs registered; RAM strobes are only
  // non-zero during ACCESS and reset clears them asynchronously so an
  // abandoned store never commits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      pending_r    <= 1'b0;
      op_r         <= 4'd0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      o_req_ready  <= 1'b1;
      o_rsp_valid  <= 1'b0;
      o_rdata      <= 32'd0;
      o_exc        <= EXC_NONE;
      o_badaddr    <= 32'd0;
      o_ram_addr   <= 32'd0;
      o_ram_rsize  <= 3'd0;
      o_ram_rsign  <= 1'b0;
      o_ram_wsize  <= 3'd0;
      o_ram_wdata  <= 32'd0;
`ifdef LSU_MMIO_EN
      o_mmio_req   <= 1'b0;
      o_mmio_we    <= 1'b0;
      o_mmio_addr  <= 32'd0;
      o_mmio_wdata <= 32'd0;
      o_mmio_size  <= 3'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pending_r) begin
            pending_r <= 1'b0;
            if (chk_exc != EXC_NONE) begin
              // Faulting request: answer directly, RAM stays untouched.
              o_exc       <= chk_exc;
              o_badaddr   <= addr_r;
              o_rdata     <= 32'd0;
              o_rsp_valid <= 1'b1;
              state_r     <= ST_RESP;
            end
`ifdef LSU_MMIO_EN
            else if (chk_is_mmio) begin
              o_mmio_req   <= 1'b1;
              o_mmio_we    <= chk_is_store;
              o_mmio_addr  <= addr_r;
              o_mmio_wdata <= chk_is_store ? wdata_r : 32'd0;
              o_mmio_size  <= chk_nbytes;
              state_r      <= ST_MMIO_WAIT;
            end
`endif
            else begin
              o_ram_addr <= addr_r;
              if (chk_is_store) begin
                o_ram_wsize <= chk_nbytes;
                o_ram_wdata <= wdata_r;
              end else begin
                o_ram_rsize <= chk_nbytes;
                o_ram_rsign <= ~chk_is_unsigned;
              end
              state_r <= ST_ACCESS;
            end
          end else if (i_req_valid) begin
            op_r        <= i_op;
            addr_r      <= i_addr;
            wdata_r     <= i_wdata;
            pending_r   <= 1'b1;
            o_req_ready <= 1'b0;
          end else begin
            o_req_ready <= 1'b1;
          end
        end

        ST_ACCESS: begin
          // The RAM read is combinational; its value is valid this cycle.
          o_rdata     <= chk_is_store ? 32'd0 : i_ram_rdata;
          o_exc       <= EXC_NONE;
          o_badaddr   <= 32'd0;
          o_rsp_valid <= 1'b1;
          o_ram_addr  <= 32'd0;
          o_ram_rsize <= 3'd0;
          o_ram_rsign <= 1'b0;
          o_ram_wsize <= 3'd0;
          o_ram_wdata <= 32'd0;
          state_r     <= ST_RESP;
        end

        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_rdata     <= 32'd0;
            o_exc       <= EXC_NONE;
            o_badaddr   <= 32'd0;
            o_req_ready <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            o_rsp_valid <= 1'b1;
          end
        end

`ifdef LSU_MMIO_EN
        ST_MMIO_WAIT: begin
          if (i_mmio_ack) begin
            o_mmio_req   <= 1'b0;
            o_mmio_we    <= 1'b0;
            o_mmio_addr  <= 32'd0;
            o_mmio_wdata <= 32'd0;
            o_mmio_size  <= 3'd0;
            o_rdata      <= chk_is_store ? 32'd0
                                         : extend_load(i_mmio_rdata, op_r[1:0], chk_is_unsigned);
            o_exc        <= EXC_NONE;
            o_badaddr    <= 32'd0;
            o_rsp_valid  <= 1'b1;
            state_r      <= ST_RESP;
          end else begin
            o_mmio_req <= 1'b1;
          end
        end
`endif

        default: begin
          state_r     <= ST_IDLE;
          pending_r   <= 1'b0;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_ram_rsize <= 3'd0;
          o_ram_wsize <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage with a big-endian byte RAM model.
module tb_lsu_stage;
  localparam int MEM = 1024;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [3:0]  i_op;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rdata;
  logic [1:0]  o_exc;
  logic [31:0] o_badaddr;
  logic [31:0] o_ram_addr;
  logic [2:0]  o_ram_rsize;
  logic        o_ram_rsign;
  logic [2:0]  o_ram_wsize;
  logic [31:0] o_ram_wdata;
  logic [31:0] i_ram_rdata;

  int errors = 0;
  int checks = 0;

  // RAM model state
  logic [7:0] mem [0:MEM-1];
  logic       mem_init_done = 1'b0;
  int         write_count = 0;
  int         act_count = 0;

  // values observed by do_req
  int          lat;
  logic [2:0]  acc_wsize, acc_rsize;
  logic        acc_rsign;
  logic [31:0] acc_addr, acc_wdata;

  lsu_stage #(.MEM_SIZE(MEM)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_op        (i_op),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rdata     (o_rdata),
    .o_exc       (o_exc),
    .o_badaddr   (o_badaddr),
    .o_ram_addr  (o_ram_addr),
    .o_ram_rsize (o_ram_rsize),
    .o_ram_rsign (o_ram_rsign),
    .o_ram_wsize (o_ram_wsize),
    .o_ram_wdata (o_ram_wdata),
    .i_ram_rdata (i_ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational big-endian read with size/sign select.
  always_comb begin
    logic [9:0] ra;
    logic [7:0] b0, b1, b2, b3;
    ra = o_ram_addr[9:0];
    b0 = mem[ra];
    b1 = mem[ra + 10'd1];
    b2 = mem[ra + 10'd2];
    b3 = mem[ra + 10'd3];
    case (o_ram_rsize)
      3'd1: i_ram_rdata = o_ram_rsign ? {{24{b0[7]}}, b0} : {24'd0, b0};
      3'd2: i_ram_rdata = o_ram_rsign ? {{16{b0[7]}}, b0, b1} : {16'd0, b0, b1};
      3'd4: i_ram_rdata = {b0, b1, b2, b3};
      default: i_ram_rdata = 32'd0;
    endcase
  end

  // Initial fill, then big-endian writes committed on the clock edge.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < MEM; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else begin
      case (o_ram_wsize)
        3'd1: mem[o_ram_addr[9:0]] <= o_ram_wdata[7:0];
        3'd2: begin
          mem[o_ram_addr[9:0]]         <= o_ram_wdata[15:8];
          mem[o_ram_addr[9:0] + 10'd1] <= o_ram_wdata[7:0];
        end
        3'd4: begin
          mem[o_ram_addr[9:0]]         <= o_ram_wdata[31:24];
          mem[o_ram_addr[9:0] + 10'd1] <= o_ram_wdata[23:16];
          mem[o_ram_addr[9:0] + 10'd2] <= o_ram_wdata[15:8];
          mem[o_ram_addr[9:0] + 10'd3] <= o_ram_wdata[7:0];
        end
        default: ;
      endcase
    end
    if (o_ram_wsize != 3'd0) write_count <= write_count + 1;
    if (o_ram_wsize != 3'd0 || o_ram_rsize != 3'd0) act_count <= act_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait for its response (left pending in RESP).
  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    while (!o_req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_before_req", {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1;
    i_op        = op;
    i_addr      = addr;
    i_wdata     = wdata;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    acc_wsize = 3'd0; acc_rsize = 3'd0; acc_rsign = 1'b0;
    acc_addr  = 32'd0; acc_wdata = 32'd0;
    lat = 0;
    while (!o_rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (o_ram_wsize != 3'd0 || o_ram_rsize != 3'd0) begin
        acc_wsize = o_ram_wsize; acc_rsize = o_ram_rsize; acc_rsign = o_ram_rsign;
        acc_addr  = o_ram_addr;  acc_wdata = o_ram_wdata;
      end
    end
    check("rsp_valid_seen", {31'd0, o_rsp_valid}, 32'd1);
  endtask

  // Take the response and confirm the LSU returns to IDLE.
  task automatic take_rsp();
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    check("rsp_valid_dropped", {31'd0, o_rsp_valid}, 32'd0);
    check("req_ready_back", {31'd0, o_req_ready}, 32'd1);
  endtask

  initial begin
    int wc0, ac0;
    rst_n = 1'b0; i_req_valid = 1'b0; i_rsp_ready = 1'b0;
    i_op = 4'd0; i_addr = 32'd0; i_wdata = 32'd0;
    @(posedge clk); #1;
    mem_init_done = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    check("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_exc", {30'd0, o_exc}, 32'd0);
    check("rst_badaddr", o_badaddr, 32'd0);
    check("rst_ram_wsize", {29'd0, o_ram_wsize}, 32'd0);
    check("rst_ram_rsize", {29'd0, o_ram_rsize}, 32'd0);

    // SW 0x10
    wc0 = write_count;
    do_req(4'b1010, 32'h10, 32'hDEADBEEF);
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_wsize", {29'd0, acc_wsize}, 32'd4);
    check("sw_rsize", {29'd0, acc_rsize}, 32'd0);
    check("sw_addr", acc_addr, 32'h10);
    check("sw_wdata", acc_wdata, 32'hDEADBEEF);
    check("sw_exc", {30'd0, o_exc}, 32'd0);
    check("sw_rdata", o_rdata, 32'd0);
    take_rsp();
    check("sw_one_write", 32'(write_count - wc0), 32'd1);

    // LB 0x10
    do_req(4'b0000, 32'h10, 32'd0);
    check("lb_latency", 32'(lat), 32'd2);
    check("lb_rsize", {29'd0, acc_rsize}, 32'd1);
    check("lb_rsign", {31'd0, acc_rsign}, 32'd1);
    check("lb_rdata", o_rdata, 32'hFFFFFFDE);
    take_rsp();

    // LBU 0x13
    do_req(4'b0100, 32'h13, 32'd0);
    check("lbu_rsign", {31'd0, acc_rsign}, 32'd0);
    check("lbu_rdata", o_rdata, 32'h000000EF);
    take_rsp();

    // LH 0x12
    do_req(4'b0001, 32'h12, 32'd0);
    check("lh_rsize", {29'd0, acc_rsize}, 32'd2);
    check("lh_rdata", o_rdata, 32'hFFFFBEEF);
    take_rsp();

    // SH 0x20 then LW 0x20: bytes 0x22/0x23 keep their fill (0x78, 0x79)
    do_req(4'b1001, 32'h20, 32'h1234ABCD);
    check("sh_wsize", {29'd0, acc_wsize}, 32'd2);
    take_rsp();
    do_req(4'b0010, 32'h20, 32'd0);
    check("lw_after_sh", o_rdata, 32'hABCD7879);
    take_rsp();

    // misaligned LW 0x6
    ac0 = act_count;
    do_req(4'b0010, 32'h6, 32'd0);
    check("mis_latency", 32'(lat), 32'd1);
    check("mis_exc", {30'd0, o_exc}, 32'd1);
    check("mis_badaddr", o_badaddr, 32'h6);
    check("mis_rdata", o_rdata, 32'd0);
    check("mis_no_ram", 32'(act_count - ac0), 32'd0);
    take_rsp();

    // LW at MEM_SIZE -> bus error
    do_req(4'b0010, 32'(MEM), 32'd0);
    check("bus_exc", {30'd0, o_exc}, 32'd2);
    check("bus_badaddr", o_badaddr, 32'h400);
    take_rsp();

    // LW at MEM_SIZE-4 is legal
    do_req(4'b0010, 32'(MEM - 4), 32'd0);
    check("top_word_exc", {30'd0, o_exc}, 32'd0);
    check("top_word_rdata", o_rdata, 32'hA6A7A4A5);
    take_rsp();

    // LW at MEM_SIZE-2: misaligned beats bus error
    do_req(4'b0010, 32'(MEM - 2), 32'd0);
    check("mis_over_bus", {30'd0, o_exc}, 32'd1);
    take_rsp();

    // illegal size on an out-of-range misaligned address: illegal wins
    ac0 = act_count;
    do_req(4'b0011, 32'h401, 32'd0);
    check("ill_exc", {30'd0, o_exc}, 32'd3);
    check("ill_badaddr", o_badaddr, 32'h401);
    check("ill_no_ram", 32'(act_count - ac0), 32'd0);
    take_rsp();

    // backpressure with a second request waiting
    wc0 = write_count;
    do_req(4'b1010, 32'h30, 32'hCAFEF00D);
    i_req_valid = 1'b1; i_op = 4'b0010; i_addr = 32'h30; i_wdata = 32'd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
      check("bp_req_ready", {31'd0, o_req_ready}, 32'd0);
      check("bp_exc", {30'd0, o_exc}, 32'd0);
    end
    i_req_valid = 1'b0;
    take_rsp();
    check("bp_one_write", 32'(write_count - wc0), 32'd1);
    do_req(4'b0010, 32'h30, 32'd0);
    check("bp_readback", o_rdata, 32'hCAFEF00D);
    take_rsp();

    // reset during the ACCESS cycle of SW 0x40 (fill word 0x1A1B1819)
    wc0 = write_count;
    i_req_valid = 1'b1; i_op = 4'b1010; i_addr = 32'h40; i_wdata = 32'h11223344;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_in_access", {29'd0, o_ram_wsize}, 32'd4);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wsize", {29'd0, o_ram_wsize}, 32'd0);
    check("rst_mid_ram_addr", o_ram_addr, 32'd0);
    check("rst_mid_req_ready", {31'd0, o_req_ready}, 32'd1);
    check("rst_mid_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_no_write", 32'(write_count - wc0), 32'd0);
    do_req(4'b0010, 32'h40, 32'd0);
    check("rst_mid_word_kept", o_rdata, 32'h1A1B1819);
    take_rsp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
